// File: rtl/rename_pkg.sv
// Shared definitions for the rename stage: default sizes, free-list depth,
// register index typedefs and a pointer-width helper.
package rename_pkg;

    localparam int ARCH_REGS_DEF = 32;
    localparam int PHYS_REGS_DEF = 64;
    localparam int FL_DEPTH_DEF  = PHYS_REGS_DEF - ARCH_REGS_DEF;

    typedef logic [$clog2(ARCH_REGS_DEF)-1:0] areg_t;
    typedef logic [$clog2(PHYS_REGS_DEF)-1:0] preg_t;

    // Pointer width for a circular buffer; a depth of one still needs one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rename_free_list.sv
// Circular free list of physical registers. Pops from head on allocation,
// pushes at tail on retire. Optional feature macro: RENAME_FLUSH_EN adds a
// committed head pointer and a restore input that rewinds head to it.
module rename_free_list
    import rename_pkg::*;
#(
    parameter int DEPTH = FL_DEPTH_DEF,
    parameter int PW    = $clog2(PHYS_REGS_DEF),
    parameter int BASE  = ARCH_REGS_DEF,
    localparam int PTRW = ptr_width(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pop,
    input  logic          push,
    input  logic [PW-1:0] push_data,
    output logic [PW-1:0] head_data,
    output logic [CW-1:0] count
`ifdef RENAME_FLUSH_EN
    ,
    input  logic          commit,
    input  logic          restore
`endif
);

    logic [PW-1:0]   mem [DEPTH];
    logic [PTRW-1:0] head;
    logic [PTRW-1:0] tail;
    logic [CW-1:0]   count_n;
    logic            restore_i;
    logic [PTRW-1:0] restore_head;
    logic [CW-1:0]   restore_cnt;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_data = mem[head];

    // Occupancy: a simultaneous pop and push leaves the count unchanged.
    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

`ifdef RENAME_FLUSH_EN
    logic [PTRW-1:0] chead;
    logic [PTRW-1:0] chead_n;
    logic [PTRW-1:0] tail_n;
    int              diff;

    // Restore target includes this cycle's commit and retire. The committed
    // state always frees exactly DEPTH registers, so tail==chead means full.
    always_comb begin
        chead_n      = commit ? ptr_inc(chead) : chead;
        tail_n       = push ? ptr_inc(tail) : tail;
        diff         = (tail_n >= chead_n) ? int'(tail_n) - int'(chead_n)
                                           : int'(tail_n) + DEPTH - int'(chead_n);
        restore_i    = restore;
        restore_head = chead_n;
        restore_cnt  = (diff == 0) ? CW'(DEPTH) : CW'(diff);
    end

    // Committed head advances once per committed destination.
    always_ff @(posedge clk) begin
        if (rst) chead <= '0;
        else     chead <= chead_n;
    end
`else
    // Without flush recovery there is nothing to restore.
    always_comb begin
        restore_i    = 1'b0;
        restore_head = '0;
        restore_cnt  = '0;
    end
`endif

    // Storage and pointers: reset loads the non-architectural registers in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= PW'(BASE + i);
            head  <= '0;
            tail  <= '0;
            count <= CW'(DEPTH);
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ptr_inc(tail);
            end
            if (restore_i) begin
                head  <= restore_head;
                count <= restore_cnt;
            end else begin
                if (pop) head <= ptr_inc(head);
                count <= count_n;
            end
        end
    end

    // Returning a register to an already full list means a double free upstream.
    assert property (@(posedge clk) disable iff (rst) !(push && (count == CW'(DEPTH))));

endmodule

// File: rtl/rename_map_unit.sv
// Register-rename stage: speculative RAT plus circular free list, one
// instruction per cycle, registered output with valid/ready.
// Optional feature macro: RENAME_FLUSH_EN adds a committed RAT and flush
// recovery (ports flush, ret_areg, ret_new_p).
module rename_map_unit
    import rename_pkg::*;
#(
    parameter int ARCH_REGS = ARCH_REGS_DEF,
    parameter int PHYS_REGS = PHYS_REGS_DEF,
    localparam int AW = $clog2(ARCH_REGS),
    localparam int PW = $clog2(PHYS_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] sr1,
    input  logic [AW-1:0] sr2,
    input  logic [AW-1:0] dr,
    input  logic          writes_dr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] sr1_p,
    output logic [PW-1:0] sr2_p,
    output logic [PW-1:0] dr_p,
    output logic [PW-1:0] old_dr_p,
    output logic          has_dr,
    input  logic          ret_valid,
    input  logic          ret_has_dr,
    input  logic [PW-1:0] ret_old_p
`ifdef RENAME_FLUSH_EN
    ,
    input  logic [AW-1:0] ret_areg,
    input  logic [PW-1:0] ret_new_p,
    input  logic          flush
`endif
);

    localparam int DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int CW    = $clog2(DEPTH + 1);

    logic [PW-1:0] rat [ARCH_REGS];
    logic          alloc;
    logic          accept;
    logic          fl_pop;
    logic          fl_push;
    logic          flush_i;
    logic [PW-1:0] fl_head;
    logic [CW-1:0] fl_count;

`ifdef RENAME_FLUSH_EN
    logic [PW-1:0] crat [ARCH_REGS];
    logic          commit;

    assign commit  = ret_valid && ret_has_dr;
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // Stall on an empty list even for non-allocating instructions; frees
    // arriving this cycle are not bypassed.
    assign in_ready = (!out_valid || out_ready) && (fl_count != '0) && !flush_i;
    assign accept   = in_valid && in_ready;
    assign alloc    = writes_dr && (dr != '0);
    assign fl_pop   = accept && alloc;
    assign fl_push  = ret_valid && ret_has_dr && (ret_old_p != '0);

    rename_free_list #(
        .DEPTH (DEPTH),
        .PW    (PW),
        .BASE  (ARCH_REGS)
    ) u_free_list (
        .clk       (clk),
        .rst       (rst),
        .pop       (fl_pop),
        .push      (fl_push),
        .push_data (ret_old_p),
        .head_data (fl_head),
        .count     (fl_count)
`ifdef RENAME_FLUSH_EN
        ,
        .commit    (commit),
        .restore   (flush)
`endif
    );

`ifdef RENAME_FLUSH_EN
    // Committed map follows the ROB's retired destinations.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) crat[i] <= PW'(i);
        end else if (commit) begin
            crat[ret_areg] <= ret_new_p;
        end
    end
`endif

    // Speculative map: identity at reset, rewound on flush, else updated on allocation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) rat[i] <= PW'(i);
        end else if (flush_i) begin
`ifdef RENAME_FLUSH_EN
            for (int i = 0; i < ARCH_REGS; i++) rat[i] <= crat[i];
            if (commit) rat[ret_areg] <= ret_new_p;
`endif
        end else if (fl_pop) begin
            rat[dr] <= fl_head;
        end
    end

    // Output register: sources read the map before this instruction's own update.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sr1_p     <= '0;
            sr2_p     <= '0;
            dr_p      <= '0;
            old_dr_p  <= '0;
            has_dr    <= 1'b0;
        end else if (flush_i) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            sr1_p     <= rat[sr1];
            sr2_p     <= rat[sr2];
            if (alloc) begin
                dr_p     <= fl_head;
                old_dr_p <= rat[dr];
                has_dr   <= 1'b1;
            end else begin
                dr_p     <= rat[dr];
                old_dr_p <= '0;
                has_dr   <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rename_map_unit.sv
// Scoreboard bench for rename_map_unit: a queue-based reference model
// predicts each renamed instruction, a monitor compares DUT output.
module tb_rename_map_unit;

    localparam int AR = 32;
    localparam int PR = 64;
    localparam int AW = 5;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] sr1 = '0, sr2 = '0, dr = '0;
    logic          writes_dr = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [PW-1:0] sr1_p, sr2_p, dr_p, old_dr_p;
    logic          has_dr;
    logic          ret_valid = 1'b0;
    logic          ret_has_dr = 1'b0;
    logic [PW-1:0] ret_old_p = '0;
`ifdef RENAME_FLUSH_EN
    logic [AW-1:0] ret_areg = '0;
    logic [PW-1:0] ret_new_p = '0;
    logic          flush = 1'b0;
`endif

    rename_map_unit #(.ARCH_REGS(AR), .PHYS_REGS(PR)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sr1        (sr1),
        .sr2        (sr2),
        .dr         (dr),
        .writes_dr  (writes_dr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sr1_p      (sr1_p),
        .sr2_p      (sr2_p),
        .dr_p       (dr_p),
        .old_dr_p   (old_dr_p),
        .has_dr     (has_dr),
        .ret_valid  (ret_valid),
        .ret_has_dr (ret_has_dr),
        .ret_old_p  (ret_old_p)
`ifdef RENAME_FLUSH_EN
        ,
        .ret_areg   (ret_areg),
        .ret_new_p  (ret_new_p),
        .flush      (flush)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] s1;
        logic [PW-1:0] s2;
        logic [PW-1:0] d;
        logic [PW-1:0] o;
        logic          h;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;

    logic [PW-1:0] m_rat [AR];
    logic [PW-1:0] m_crat [AR];
    logic [PW-1:0] m_free[$];
    logic [PW-1:0] m_spec[$];
    logic [PW-1:0] m_pend[$];
    bit            m_ov;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < AR; i++) begin
            m_rat[i]  = PW'(i);
            m_crat[i] = PW'(i);
        end
        m_free.delete();
        for (int i = AR; i < PR; i++) m_free.push_back(PW'(i));
        m_spec.delete();
        m_pend.delete();
        sb.delete();
        m_ov = 0;
    endtask

    // Monitor: every presented output must match the oldest prediction;
    // a stalled output is re-checked each cycle, popped only on transfer.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected dr_p %0d with empty scoreboard at %0t", dr_p, $time);
            end else begin
                if (sr1_p !== sb[0].s1 || sr2_p !== sb[0].s2 || dr_p !== sb[0].d ||
                    old_dr_p !== sb[0].o || has_dr !== sb[0].h) begin
                    errors++;
                    $display("FAIL rename_out actual %0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d at %0t",
                             sr1_p, sr2_p, dr_p, old_dr_p, has_dr,
                             sb[0].s1, sb[0].s2, sb[0].d, sb[0].o, sb[0].h, $time);
                end
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    // One clock: check handshake against the model, advance the model with the
    // inputs currently driven, then move to just after the next rising edge.
    task automatic tick();
        exp_t e;
        bit   exp_rdy;
        bit   fl;
        @(negedge clk);
        fl = 0;
`ifdef RENAME_FLUSH_EN
        fl = flush;
`endif
        check("out_valid", 32'(out_valid), 32'(m_ov));
        exp_rdy = (!m_ov || out_ready) && (m_free.size() != 0) && !fl;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (in_valid && exp_rdy) begin
            e.s1 = m_rat[sr1];
            e.s2 = m_rat[sr2];
            if (writes_dr && dr != 0) begin
                e.d = m_free.pop_front();
                e.o = m_rat[dr];
                e.h = 1'b1;
                m_rat[dr] = e.d;
                m_pend.push_back(e.o);
                m_spec.push_back(e.d);
            end else begin
                e.d = m_rat[dr];
                e.o = '0;
                e.h = 1'b0;
            end
            sb.push_back(e);
            m_ov = 1;
        end else if (out_ready) begin
            m_ov = 0;
        end
        if (ret_valid && ret_has_dr && ret_old_p != 0) m_free.push_back(ret_old_p);
`ifdef RENAME_FLUSH_EN
        if (ret_valid && ret_has_dr) begin
            m_crat[ret_areg] = ret_new_p;
            void'(m_spec.pop_front());
        end
        if (flush) begin
            for (int i = 0; i < AR; i++) m_rat[i] = m_crat[i];
            while (m_spec.size() != 0) m_free.push_front(m_spec.pop_back());
            m_ov = 0;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        writes_dr  = 1'b0;
        out_ready  = 1'b1;
        ret_valid  = 1'b0;
        ret_has_dr = 1'b0;
        ret_old_p  = '0;
`ifdef RENAME_FLUSH_EN
        flush      = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sr1_p", 32'(sr1_p), 0);
        check("rst_dr_p", 32'(dr_p), 0);
        check("rst_old_dr_p", 32'(old_dr_p), 0);
        check("rst_has_dr", 32'(has_dr), 0);
        check("rst_in_ready", 32'(in_ready), 1);
    endtask

    task automatic set_in(input bit v, input int s1, input int s2, input int d, input bit w);
        in_valid  = v;
        sr1       = AW'(s1);
        sr2       = AW'(s2);
        dr        = AW'(d);
        writes_dr = w;
    endtask

    task automatic set_ret(input bit v, input bit h, input int p);
        ret_valid  = v;
        ret_has_dr = h;
        ret_old_p  = PW'(p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        do_reset();

        // Back-to-back dependence and non-allocating forms.
        set_in(1, 5, 0, 5, 1); tick();   // sr1_p=5 dr_p=32 old=5
        set_in(1, 5, 5, 6, 1); tick();   // sr1_p=32 dr_p=33
        set_in(1, 6, 5, 0, 1); tick();   // dr=0: no allocation
        set_in(1, 3, 6, 7, 0); tick();   // store-like: dr_p=RAT[7]
        set_in(0, 0, 0, 0, 0); tick(); tick();

        // Exhaust the free list, stall, then recover through a retire.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            set_in(1, i % 32, (i + 7) % 32, (i % 31) + 1, 1);
            tick();
        end
        set_in(1, 2, 3, 4, 0); tick();   // empty: even a non-allocating op stalls
        set_ret(1, 1, 5);      tick();   // freed reg not bypassed this cycle
        set_ret(0, 0, 0);
        set_in(1, 1, 2, 9, 1); tick();   // next dr_p=5
        set_in(0, 0, 0, 0, 0); tick(); tick();

        // Output backpressure holds the output and blocks input.
        do_reset();
        set_in(1, 9, 9, 9, 1); tick();
        out_ready = 1'b0;
        set_in(1, 9, 1, 10, 1);
        repeat (3) tick();
        out_ready = 1'b1;      tick();
        set_in(0, 0, 0, 0, 0); tick(); tick();

        // Reset with an output in flight drops it.
        set_in(1, 4, 5, 11, 1); out_ready = 1'b0; tick();
        do_reset();

        // Steady alloc+retire at count 1 wraps both pointers.
        for (int i = 0; i < 31; i++) begin
            set_in(1, i, 0, i + 1, 1);
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            set_in(1, (k + 3) % 32, k % 32, (k % 31) + 1, 1);
            set_ret(1, 1, int'(m_pend.pop_front()));
            tick();
        end
        set_ret(1, 1, 0);
        set_in(0, 0, 0, 0, 0); tick();   // old mapping p0 is never freed
        set_ret(0, 0, 0);      tick();
        set_in(1, 1, 2, 3, 1); tick();
        set_in(0, 0, 0, 0, 0); tick();

`ifdef RENAME_FLUSH_EN
        // Flush restores the committed map and head.
        do_reset();
        set_in(1, 0, 0, 3, 1); tick();   // r3 -> p32
        set_in(1, 0, 0, 4, 1); tick();   // r4 -> p33
        set_in(0, 0, 0, 0, 0);
        set_ret(1, 1, 3);
        ret_areg = AW'(3); ret_new_p = PW'(32);
        tick();
        set_ret(0, 0, 0);      tick();
        flush = 1'b1;          tick();
        flush = 1'b0;
        set_in(1, 3, 4, 7, 1); tick();   // sr1_p=32 sr2_p=4 dr_p=33
        set_in(0, 0, 0, 0, 0); tick();
`endif

        for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rename_map_unit.md
# rename_map_unit

Parametrised register-rename stage between decode and dispatch. Maps architectural source and destination registers to physical registers through a speculative RAT and a circular free list, and returns freed physical registers at commit. One instruction per cycle with valid/ready handshakes and a registered output. Optional flush recovery restores the committed mapping.

## Interface
- ARCH_REGS, 32, architectural register count (power of 2, ≥2)
- PHYS_REGS, 64, physical register count (> ARCH_REGS)
- AW, $clog2(ARCH_REGS), architectural index width (derived)
- PW, $clog2(PHYS_REGS), physical index width (derived)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  rename accepts this cycle
- sr1, sr2, dr  in  AW each  architectural sources/destination
- writes_dr  in  1  instruction writes dr (0 for stores, branches, NOP)
- out_valid  out  1  renamed instruction held in output register
- out_ready  in  1  dispatch consumes output
- sr1_p, sr2_p, dr_p, old_dr_p  out  PW each  renamed sources, new dest, previous dest mapping
- has_dr  out  1  dr_p/old_dr_p meaningful
- ret_valid  in  1  ROB commits one instruction
- ret_has_dr  in  1  committed instruction allocated a dest
- ret_old_p  in  PW  physical register to free (committed old_dr_p)
- ret_areg  in  AW  committed architectural dest (RENAME_FLUSH_EN only)
- ret_new_p  in  PW  committed new dest (RENAME_FLUSH_EN only)
- flush  in  1  discard speculative state (RENAME_FLUSH_EN only)

## Operation
- Reset: RAT[i]=i; free list holds ARCH_REGS..PHYS_REGS-1 ascending, head=tail=0, count=PHYS_REGS-ARCH_REGS; out_valid=0, all output payloads 0, has_dr=0.
- alloc = writes_dr && dr!=0. Register 0 always maps to p0 and is never allocated or freed.
- Accept when in_valid && in_ready: sr1_p/sr2_p read RAT before this instruction's own update (sr1==dr yields old mapping); if alloc, dr_p=free list head, old_dr_p=RAT[dr], RAT[dr]<=dr_p, head++, count--, has_dr=1; else dr_p=RAT[dr], old_dr_p=0, has_dr=0.
- in_ready = (!out_valid || out_ready) && count!=0. Uses registered count only, no bypass of same-cycle frees; stalls on empty even for non-allocating instructions.
- Retire: if ret_valid && ret_has_dr && ret_old_p!=0, write ret_old_p at tail, tail++, count++. Same-cycle alloc and free: count unchanged, both pointers move.
- Pointers wrap modulo PHYS_REGS-ARCH_REGS; free at count==max is illegal (assertion).

## Timing
- Latency 1: accepted in cycle N, out_valid in N+1; output holds while out_valid && !out_ready.
- RAT update visible to the instruction accepted in N+1 (back-to-back dependence renamed correctly).
- Retired register allocatable from the cycle after retire.
- Reset mid-operation: all state returns to reset values next edge, in-flight output dropped.

## Configuration
- RENAME_FLUSH_EN defined: committed RAT (CRAT) and committed head pointer kept. On ret_valid && ret_has_dr: CRAT[ret_areg]<=ret_new_p, chead++. On flush: RAT<=CRAT, head<=chead (including same-cycle retire update), count<=tail-chead mod depth, out_valid<=0, input not accepted that cycle (in_ready=0). Flush has priority over accept.
- Not defined: flush, ret_areg, ret_new_p ports absent; no CRAT storage.

## Structure
- rename_pkg: default ARCH_REGS/PHYS_REGS, free-list depth constant, preg_t/areg_t typedefs.
- Sub-module rename_free_list: circular FIFO with pop/push, count, and committed-head restore under RENAME_FLUSH_EN.

## Test plan
- Reset, rename dr=5 sr1=5 writes_dr=1 -> sr1_p=5, dr_p=32, old_dr_p=5; next dr=6 sr1=5 -> sr1_p=32, dr_p=33.
- dr=0 writes_dr=1 -> has_dr=0, dr_p=0, free count unchanged.
- 32 allocations, no retire -> in_ready=0 on 33rd; retire ret_old_p=5 -> in_ready=1 next cycle, next dr_p=5.
- out_ready=0 for 3 cycles -> output stable, in_ready=0, no RAT change.
- Simultaneous alloc and retire at count=1 -> count stays 1, pointers wrap correctly after 40 cycles of this.
- RENAME_FLUSH_EN: allocate r3->p32, r4->p33, retire first, flush -> RAT[3]=32, RAT[4]=4, next allocation dr_p=33.
